// File: rtl/mc_operand_lock.sv
// ---------------------------------------------------------------------------
// mc_operand_lock
//
// Operand/enable lock for multi-cycle execute units (mul, div, ...) in EX.
// When an EX instruction first requests a unit, the block latches the
// operands and sub-op, fires one start pulse at that unit, and keeps the
// latched values on the unit inputs until the unit signals done. While the
// result waits for a downstream stall to clear, no second start is issued
// for the same instruction. A flush aborts the active unit with a kill pulse.
// lat_cnt reports how many cycles the current or most recent op has taken.
//
// Ports
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   req        in   per-unit request from EX decode, held while in EX
//   a, b       in   operands from EX
//   op         in   sub-op code from EX
//   stall_hold in   stall from later pipeline stages
//   flush      in   pipeline flush / exception
//   done       in   per-unit one-cycle result-valid pulse
//   start      out  one-cycle start pulse to the granted unit
//   kill       out  one-cycle abort to the active unit on flush
//   a_locked   out  operand A to the units
//   b_locked   out  operand B to the units
//   op_locked  out  sub-op to the units
//   active     out  one-hot owner of the lock
//   stallreq   out  stall request to pipeline control
//   lat_cnt    out  cycle count of the current or last op (saturating)
// ---------------------------------------------------------------------------
module mc_operand_lock #(
   parameter int XLEN      = 64,
   parameter int OPW       = 4,
   parameter int NUM_UNITS = 2,
   parameter int CNTW      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_UNITS-1:0] req,
   input  logic [XLEN-1:0]      a,
   input  logic [XLEN-1:0]      b,
   input  logic [OPW-1:0]       op,
   input  logic                 stall_hold,
   input  logic                 flush,
   input  logic [NUM_UNITS-1:0] done,
   output logic [NUM_UNITS-1:0] start,
   output logic [NUM_UNITS-1:0] kill,
   output logic [XLEN-1:0]      a_locked,
   output logic [XLEN-1:0]      b_locked,
   output logic [OPW-1:0]       op_locked,
   output logic [NUM_UNITS-1:0] active,
   output logic                 stallreq,
   output logic [CNTW-1:0]      lat_cnt
);

   // IDLE: no owner, operands pass straight through.
   // BUSY: a unit owns the lock and is computing.
   // HOLD: result delivered, instruction still parked in EX by a stall.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t               state;
   logic [NUM_UNITS-1:0] sel;
   logic [XLEN-1:0]      a_buf;
   logic [XLEN-1:0]      b_buf;
   logic [OPW-1:0]       op_buf;

   logic [NUM_UNITS-1:0] grant;
   logic                 any_req;
   logic                 sel_done;

   // Two's-complement trick isolates the lowest set bit: fixed priority,
   // unit 0 (mul) wins over higher indices.
   assign grant    = req & (~req + NUM_UNITS'(1));
   assign any_req  = |req;
   // Only the owning unit's done counts; done from other units is noise.
   assign sel_done = |(done & sel);

   // ------------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      start     = '0;
      kill      = '0;
      active    = '0;
      stallreq  = 1'b0;
      a_locked  = a_buf;
      b_locked  = b_buf;
      op_locked = op_buf;

      case (state)
         IDLE: begin
            // Units see live EX operands so the start cycle needs no
            // extra register stage.
            a_locked  = a;
            b_locked  = b;
            op_locked = op;
            if (!flush) begin
               start    = grant;
               stallreq = any_req;
            end
         end

         BUSY: begin
            active = sel;
            if (flush) begin
               kill = sel;
            end else begin
               // Release the pipeline in the same cycle the result arrives.
               stallreq = !sel_done;
            end
         end

         HOLD: begin
            // Unit finished; lock stays owned so nothing re-issues while
            // the instruction is still stalled in EX.
            active = sel;
         end

         default: begin
            active = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, capture buffers and latency counter
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         a_buf   <= '0;
         b_buf   <= '0;
         op_buf  <= '0;
         lat_cnt <= '0;
      end else if (flush) begin
         // Flush beats any other event. lat_cnt is kept so the aborted
         // op's duration remains visible.
         state  <= IDLE;
         sel    <= '0;
         a_buf  <= '0;
         b_buf  <= '0;
         op_buf <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  a_buf   <= a;
                  b_buf   <= b;
                  op_buf  <= op;
                  sel     <= grant;
                  lat_cnt <= CNTW'(1);
                  state   <= BUSY;
               end
            end

            BUSY: begin
               // Counts the done cycle too; saturates instead of wrapping.
               if (lat_cnt != '1) begin
                  lat_cnt <= lat_cnt + CNTW'(1);
               end
               if (sel_done) begin
                  state <= stall_hold ? HOLD : IDLE;
               end
            end

            HOLD: begin
               // The req seen in the following IDLE cycle belongs to the
               // next instruction.
               if (!stall_hold) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_operand_lock.sv
// ---------------------------------------------------------------------------
// tb_mc_operand_lock
//
// Drives two instances of mc_operand_lock from the same stimulus: one with
// default parameters and one with a 2-bit latency counter. A behavioural
// model (owner index, delivered flag, captured operands, unbounded cycle
// count) predicts every output each cycle; directed scenarios add literal
// expectations, then a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_mc_operand_lock;

   localparam int XLEN = 64;
   localparam int OPW  = 4;
   localparam int NU   = 2;

   logic            clk;
   logic            rst_n;
   logic [NU-1:0]   req;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [OPW-1:0]  op;
   logic            stall_hold;
   logic            flush;
   logic [NU-1:0]   done;

   logic [NU-1:0]   start, kill, active;
   logic [XLEN-1:0] a_locked, b_locked;
   logic [OPW-1:0]  op_locked;
   logic            stallreq;
   logic [7:0]      lat_cnt;

   logic [NU-1:0]   s_start, s_kill, s_active;
   logic [XLEN-1:0] s_a_locked, s_b_locked;
   logic [OPW-1:0]  s_op_locked;
   logic            s_stallreq;
   logic [1:0]      s_lat_cnt;

   mc_operand_lock #(.XLEN(XLEN), .OPW(OPW), .NUM_UNITS(NU), .CNTW(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .op(op),
      .stall_hold(stall_hold), .flush(flush), .done(done),
      .start(start), .kill(kill), .a_locked(a_locked), .b_locked(b_locked),
      .op_locked(op_locked), .active(active), .stallreq(stallreq),
      .lat_cnt(lat_cnt)
   );

   mc_operand_lock #(.XLEN(XLEN), .OPW(OPW), .NUM_UNITS(NU), .CNTW(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .op(op),
      .stall_hold(stall_hold), .flush(flush), .done(done),
      .start(s_start), .kill(s_kill), .a_locked(s_a_locked),
      .b_locked(s_b_locked), .op_locked(s_op_locked), .active(s_active),
      .stallreq(s_stallreq), .lat_cnt(s_lat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Model: which unit owns the lock (-1 none), whether its result has
   // already been delivered, what was captured, and how long the op ran.
   int              m_owner;
   bit              m_held;
   logic [XLEN-1:0] m_a, m_b;
   logic [OPW-1:0]  m_op;
   int              m_cycles;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int lowest(input logic [NU-1:0] r);
      for (int i = 0; i < NU; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic int sat(input int v, input int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_held   = 1'b0;
      m_a      = '0;
      m_b      = '0;
      m_op     = '0;
      m_cycles = 0;
   endtask

   // Advance the model with the inputs that were present at the edge.
   task automatic model_step();
      int g;
      g = lowest(req);
      if (!rst_n) begin
         model_reset();
      end else if (flush) begin
         m_owner = -1;
         m_held  = 1'b0;
         m_a     = '0;
         m_b     = '0;
         m_op    = '0;
      end else if (m_owner < 0) begin
         if (g >= 0) begin
            m_owner  = g;
            m_a      = a;
            m_b      = b;
            m_op     = op;
            m_cycles = 1;
         end
      end else if (!m_held) begin
         m_cycles++;
         if (done[m_owner]) begin
            if (stall_hold) m_held = 1'b1;
            else            m_owner = -1;
         end
      end else if (!stall_hold) begin
         m_owner = -1;
         m_held  = 1'b0;
      end
   endtask

   task automatic compare_all();
      logic [NU-1:0]   e_start, e_kill, e_active;
      logic            e_stall;
      logic [XLEN-1:0] e_a, e_b;
      logic [OPW-1:0]  e_op;
      int              g;
      g = lowest(req);
      if (m_owner < 0) begin
         e_active = '0;
         e_kill   = '0;
         e_a      = a;
         e_b      = b;
         e_op     = op;
         if (!flush && g >= 0) begin
            e_start = NU'(1 << g);
            e_stall = 1'b1;
         end else begin
            e_start = '0;
            e_stall = 1'b0;
         end
      end else begin
         e_start  = '0;
         e_active = NU'(1 << m_owner);
         e_a      = m_a;
         e_b      = m_b;
         e_op     = m_op;
         e_kill   = (flush && !m_held) ? e_active : '0;
         e_stall  = (flush || m_held) ? 1'b0 : !done[m_owner];
      end
      check("start",     64'(start),     64'(e_start));
      check("kill",      64'(kill),      64'(e_kill));
      check("active",    64'(active),    64'(e_active));
      check("stallreq",  64'(stallreq),  64'(e_stall));
      check("a_locked",  a_locked,       e_a);
      check("b_locked",  b_locked,       e_b);
      check("op_locked", 64'(op_locked), 64'(e_op));
      check("lat_cnt",   64'(lat_cnt),   64'(sat(m_cycles, 255)));
      check("s_start",   64'(s_start),   64'(e_start));
      check("s_active",  64'(s_active),  64'(e_active));
      check("s_lat_cnt", 64'(s_lat_cnt), 64'(sat(m_cycles, 3)));
   endtask

   task automatic begin_cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic finish_cycle();
      @(negedge clk);
      compare_all();
   endtask

   task automatic apply(input logic [NU-1:0] rq, input logic [XLEN-1:0] av,
                        input logic [XLEN-1:0] bv, input logic [OPW-1:0] ov,
                        input logic st, input logic fl, input logic [NU-1:0] dn,
                        input logic rs);
      begin_cycle();
      rst_n      = rs;
      req        = rq;
      a          = av;
      b          = bv;
      op         = ov;
      stall_hold = st;
      flush      = fl;
      done       = dn;
      finish_cycle();
   endtask

   initial begin
      rst_n = 1'b0; req = '0; a = '0; b = '0; op = '0;
      stall_hold = 1'b0; flush = 1'b0; done = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_active",   64'(active),   64'h0);
      check("rst_stallreq", 64'(stallreq), 64'h0);
      check("rst_lat_cnt",  64'(lat_cnt),  64'h0);
      check("rst_kill",     64'(kill),     64'h0);
      rst_n = 1'b1;

      // Mul issue, done four cycles after start.
      apply(2'b01, 64'h12, 64'h34, 4'h3, 0, 0, 2'b00, 1);
      check("t1_start0",   64'(start),    64'h1);
      check("t1_stall0",   64'(stallreq), 64'h1);
      apply(2'b01, 64'hFF, 64'h34, 4'h3, 0, 0, 2'b00, 1);
      check("t1_start1",   64'(start),    64'h0);
      check("t1_a_held",   a_locked,      64'h12);
      apply(2'b01, 64'hFF, 64'h34, 4'h3, 0, 0, 2'b00, 1);
      apply(2'b01, 64'hFF, 64'h34, 4'h3, 0, 0, 2'b00, 1);
      check("t1_stall3",   64'(stallreq), 64'h1);
      apply(2'b01, 64'hFF, 64'h34, 4'h3, 0, 0, 2'b01, 1);
      check("t1_stall_dn", 64'(stallreq), 64'h0);
      apply(2'b00, 64'h0, 64'h0, 4'h0, 0, 0, 2'b00, 1);
      check("t1_lat",      64'(lat_cnt),  64'd5);
      check("t1_idle",     64'(active),   64'h0);

      // Div whose result lands under a stall.
      apply(2'b10, 64'h1, 64'h77, 4'h5, 0, 0, 2'b00, 1);
      check("t2_start",    64'(start),    64'h2);
      apply(2'b10, 64'h1, 64'h99, 4'h5, 0, 0, 2'b00, 1);
      apply(2'b10, 64'h1, 64'h99, 4'h5, 1, 0, 2'b10, 1);
      check("t2_stall_dn", 64'(stallreq), 64'h0);
      for (int i = 0; i < 3; i++) begin
         apply(2'b10, 64'h1, 64'hAA, 4'h5, 1, 0, 2'b00, 1);
         check("t2_hold_start", 64'(start),    64'h0);
         check("t2_hold_stall", 64'(stallreq), 64'h0);
         check("t2_hold_b",     b_locked,      64'h77);
      end
      apply(2'b10, 64'h1, 64'hAA, 4'h5, 0, 0, 2'b00, 1);
      check("t2_release_start", 64'(start), 64'h0);
      apply(2'b00, 64'h0, 64'h0, 4'h0, 0, 0, 2'b00, 1);
      check("t2_idle",     64'(active),   64'h0);

      // Both units requested: mul wins, stray div done ignored.
      apply(2'b11, 64'h5, 64'h6, 4'h1, 0, 0, 2'b00, 1);
      check("t3_start",    64'(start),    64'h1);
      apply(2'b11, 64'h5, 64'h6, 4'h1, 0, 0, 2'b10, 1);
      check("t3_active",   64'(active),   64'h1);
      check("t3_stray",    64'(stallreq), 64'h1);
      apply(2'b11, 64'h5, 64'h6, 4'h1, 0, 0, 2'b01, 1);
      check("t3_done",     64'(stallreq), 64'h0);
      apply(2'b00, 64'h0, 64'h0, 4'h0, 0, 0, 2'b00, 1);

      // Flush in the second busy cycle of a div.
      apply(2'b10, 64'h21, 64'h22, 4'h2, 0, 0, 2'b00, 1);
      apply(2'b10, 64'h21, 64'h22, 4'h2, 0, 0, 2'b00, 1);
      apply(2'b10, 64'h21, 64'h22, 4'h2, 0, 1, 2'b00, 1);
      check("t4_kill",     64'(kill),     64'h2);
      check("t4_start",    64'(start),    64'h0);
      apply(2'b00, 64'hAB, 64'h0, 4'h0, 0, 0, 2'b00, 1);
      check("t4_kill_off", 64'(kill),     64'h0);
      check("t4_pass_a",   a_locked,      64'hAB);

      // Request and flush together in IDLE.
      apply(2'b01, 64'h3, 64'h4, 4'h0, 0, 1, 2'b00, 1);
      check("t5_start",    64'(start),    64'h0);
      check("t5_stall",    64'(stallreq), 64'h0);
      apply(2'b00, 64'h0, 64'h0, 4'h0, 0, 0, 2'b00, 1);
      check("t5_idle",     64'(active),   64'h0);

      // Six-cycle op saturates the 2-bit counter; next op restarts at 1.
      apply(2'b01, 64'h9, 64'h9, 4'h0, 0, 0, 2'b00, 1);
      for (int i = 0; i < 5; i++) apply(2'b01, 64'h9, 64'h9, 4'h0, 0, 0, 2'b00, 1);
      apply(2'b01, 64'h9, 64'h9, 4'h0, 0, 0, 2'b01, 1);
      apply(2'b01, 64'h8, 64'h8, 4'h0, 0, 0, 2'b00, 1);
      check("t6_sat",      64'(s_lat_cnt), 64'd3);
      check("t6_full",     64'(lat_cnt),   64'd7);
      apply(2'b01, 64'h8, 64'h8, 4'h0, 0, 0, 2'b01, 1);
      check("t6_restart",  64'(s_lat_cnt), 64'd1);
      apply(2'b00, 64'h0, 64'h0, 4'h0, 0, 0, 2'b00, 1);

      // Reset in mid-operation: no kill, clean IDLE afterwards.
      apply(2'b10, 64'h4, 64'h4, 4'h0, 0, 0, 2'b00, 1);
      apply(2'b10, 64'h4, 64'h4, 4'h0, 0, 0, 2'b00, 1);
      apply(2'b10, 64'h4, 64'h4, 4'h0, 0, 0, 2'b00, 0);
      check("rst_mid_kill", 64'(kill),   64'h0);
      apply(2'b00, 64'h0, 64'h0, 4'h0, 0, 0, 2'b00, 1);
      check("rst_mid_act",  64'(active),  64'h0);
      check("rst_mid_lat",  64'(lat_cnt), 64'h0);

      // Randomized traffic that respects the unit protocol.
      for (int c = 0; c < 3000; c++) begin
         begin_cycle();
         rst_n      = 1'b1;
         req        = ($urandom_range(0, 9) < 4) ? 2'b00 : NU'($urandom_range(1, 3));
         a          = {$urandom, $urandom};
         b          = {$urandom, $urandom};
         op         = OPW'($urandom);
         stall_hold = ($urandom_range(0, 9) < 3);
         flush      = ($urandom_range(0, 99) < 4);
         done       = '0;
         if (m_owner >= 0 && !m_held) begin
            if ($urandom_range(0, 3) == 0) done[m_owner] = 1'b1;
            if ($urandom_range(0, 9) == 0) done[1 - m_owner] = 1'b1;
         end
         finish_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
